// File: rtl/keypad_scan_debounce_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// matrix geometry, calculator key codes and a row-pattern decoder.
package keypad_scan_debounce_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [1:0] {
    KP_SCAN     = 2'd0,
    KP_DEBOUNCE = 2'd1,
    KP_PRESSED  = 2'd2,
    KP_RELEASE  = 2'd3
  } kp_state_e;

  // Key code = row*4 + col; layout matches the calculator front panel.
  localparam logic [3:0] KEY_7   = 4'd0;
  localparam logic [3:0] KEY_8   = 4'd1;
  localparam logic [3:0] KEY_9   = 4'd2;
  localparam logic [3:0] KEY_DIV = 4'd3;
  localparam logic [3:0] KEY_4   = 4'd4;
  localparam logic [3:0] KEY_5   = 4'd5;
  localparam logic [3:0] KEY_6   = 4'd6;
  localparam logic [3:0] KEY_MUL = 4'd7;
  localparam logic [3:0] KEY_1   = 4'd8;
  localparam logic [3:0] KEY_2   = 4'd9;
  localparam logic [3:0] KEY_3   = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_CLR = 4'd12;
  localparam logic [3:0] KEY_0   = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_ADD = 4'd15;

  typedef struct packed {
    logic       single;
    logic       none;
    logic [1:0] idx;
  } row_info_t;

  function automatic row_info_t decode_rows(input logic [KP_ROWS-1:0] rs);
    row_info_t  info;
    logic [2:0] zeros;
    info  = '0;
    zeros = '0;
    for (int r = 0; r < KP_ROWS; r++) begin
      if (!rs[r]) begin
        zeros    = zeros + 3'd1;
        info.idx = 2'(r);
      end
    end
    info.single = (zeros == 3'd1);
    info.none   = (zeros == 3'd0);
    return info;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_sync2_bus.sv
// Two-flop synchronizer for a bus of independent level signals.
// Resets to all-ones so idle (pulled-up) rows read as released.
module sync2_bus #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner: rotates an active-low column drive on each 1 kHz tick,
// debounces press and release, and emits one key event per physical press.
module keypad_scan_debounce
  import keypad_scan_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic       clk_12MHz,
  input  logic       rst,
  input  logic       tick_1khz,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam logic [7:0] DT = 8'(DEBOUNCE_TICKS);

  kp_state_e  state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;
  logic [3:0] col_out_q, col_out_d;

  logic [3:0] rs;
  row_info_t  info;
  logic [7:0] cnt_inc;
  logic       same_key;

  sync2_bus #(.W(4)) u_row_sync (
    .clk_i (clk_12MHz),
    .rst_i (rst),
    .d_i   (row_in),
    .q_o   (rs)
  );

  assign info     = decode_rows(rs);
  assign same_key = info.single && (info.idx == row_q);
  // Saturating increment keeps cnt from ever wrapping past the threshold.
  assign cnt_inc  = (cnt_q >= DT) ? DT : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    if (tick_1khz) begin
      unique case (state_q)
        KP_SCAN: begin
          if (info.single) begin
            row_d = info.idx;
            cnt_d = 8'd1;
            if (DT == 8'd1) begin
              state_d = KP_PRESSED;
              code_d  = {info.idx, col_q};
              valid_d = 1'b1;
            end else begin
              state_d = KP_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        KP_DEBOUNCE: begin
          if (same_key) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DT) begin
              state_d = KP_PRESSED;
              code_d  = {row_q, col_q};
              valid_d = 1'b1;
            end
          end else begin
            cnt_d   = 8'd0;
            col_d   = col_q + 2'd1;
            state_d = KP_SCAN;
          end
        end
        KP_PRESSED: begin
          if (info.none) begin
            if (DT == 8'd1) begin
              cnt_d   = 8'd0;
              col_d   = col_q + 2'd1;
              state_d = KP_SCAN;
            end else begin
              cnt_d   = 8'd1;
              state_d = KP_RELEASE;
            end
          end
        end
        KP_RELEASE: begin
          // Any pattern other than the accepted key counts toward release.
          if (same_key) begin
            cnt_d   = 8'd0;
            state_d = KP_PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DT) begin
              cnt_d   = 8'd0;
              col_d   = col_q + 2'd1;
              state_d = KP_SCAN;
            end
          end
        end
        default: state_d = KP_SCAN;
      endcase
    end
    held_d    = (state_d == KP_PRESSED) || (state_d == KP_RELEASE);
    col_out_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clk_12MHz) begin
    if (rst) begin
      state_q   <= KP_SCAN;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      cnt_q     <= 8'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
      col_out_q <= 4'b1110;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
      col_out_q <= col_out_d;
    end
  end

  assign col_out   = col_out_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Scoreboard bench: a physical keypad model drives the rows, a tick-level
// reference model predicts key events, and a monitor pops them on key_valid.
module tb_keypad_scan_debounce;

  localparam int DT = 4;
  localparam int M_IDLE = 0;
  localparam int M_QUAL = 1;
  localparam int M_DOWN = 2;
  localparam int M_REL  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] keys = '0;

  int n_total = 0;
  int n_pass  = 0;
  int pulses  = 0;
  int exp_q[$];

  int m_col = 0;
  int m_mode = M_IDLE;
  int m_cand = 0;
  int m_run = 0;
  int m_last = 0;

  keypad_scan_debounce #(.DEBOUNCE_TICKS(DT)) dut (
    .clk_12MHz (clk),
    .rst       (rst),
    .tick_1khz (tick),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad physics: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] exp_col();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << m_col);
  endfunction

  function automatic bit m_held();
    return (m_mode == M_DOWN) || (m_mode == M_REL);
  endfunction

  task automatic accept();
    m_last = m_cand * 4 + m_col;
    exp_q.push_back(m_last);
    m_mode = M_DOWN;
  endtask

  task automatic model_step();
    int nlow;
    int lowrow;
    nlow = 0;
    lowrow = 0;
    for (int r = 0; r < 4; r++)
      if (keys[r*4+m_col]) begin
        nlow++;
        lowrow = r;
      end
    case (m_mode)
      M_IDLE:
        if (nlow == 1) begin
          m_cand = lowrow;
          m_run = 1;
          if (m_run >= DT) accept();
          else m_mode = M_QUAL;
        end else m_col = (m_col + 1) % 4;
      M_QUAL:
        if (nlow == 1 && lowrow == m_cand) begin
          m_run++;
          if (m_run >= DT) accept();
        end else begin
          m_mode = M_IDLE;
          m_col = (m_col + 1) % 4;
        end
      M_DOWN:
        if (nlow == 0) begin
          m_run = 1;
          if (m_run >= DT) begin
            m_mode = M_IDLE;
            m_col = (m_col + 1) % 4;
          end else m_mode = M_REL;
        end
      default:
        if (nlow == 1 && lowrow == m_cand) m_mode = M_DOWN;
        else begin
          m_run++;
          if (m_run >= DT) begin
            m_mode = M_IDLE;
            m_col = (m_col + 1) % 4;
          end
        end
    endcase
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (9) @(negedge clk);
      tick = 1'b1;
      @(posedge clk);
      model_step();
      @(negedge clk);
      tick = 1'b0;
      check("col_out", 32'(col_out), 32'(exp_col()));
      check("key_held", 32'(key_held), 32'(m_held()));
      check("key_code_hold", 32'(key_code), 32'(m_last));
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    m_col = 0;
    m_mode = M_IDLE;
    m_run = 0;
    m_cand = 0;
    m_last = 0;
    check("reset_col_out", 32'(col_out), 32'h0000_000E);
    check("reset_key_valid", 32'(key_valid), 32'd0);
    check("reset_key_held", 32'(key_held), 32'd0);
    check("reset_key_code", 32'(key_code), 32'd0);
  endtask

  always @(posedge clk) begin
    #2;
    if (key_valid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL key_valid_unexpected: got pulse with code %0d expected no pulse", key_code);
      end else begin
        check("key_code_event", 32'(key_code), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    int k1;
    int k2;
    int sel;

    // Reset and idle rotation
    do_reset(3);
    do_ticks(4);

    // Key row 2 / col 1 -> code 9, then release
    keys = 16'h0200;
    p0 = pulses;
    do_ticks(12);
    check("t2_held", 32'(key_held), 32'd1);
    check("t2_code", 32'(key_code), 32'd9);
    check("t2_one_pulse", 32'(pulses - p0), 32'd1);
    keys = '0;
    do_ticks(3);
    check("t2_held_during_release", 32'(key_held), 32'd1);
    do_ticks(1);
    check("t2_held_released", 32'(key_held), 32'd0);
    check("t2_resume_col2", 32'(col_out), 32'h0000_000B);

    // Bounce at row 0 / col 3
    for (int i = 0; i < 8 && !(m_col == 3 && m_mode == M_IDLE); i++) do_ticks(1);
    check("t3_col3_driven", 32'(col_out), 32'h0000_0007);
    p0 = pulses;
    keys = 16'h0008;
    do_ticks(2);
    keys = '0;
    do_ticks(1);
    check("t3_no_pulse", 32'(pulses - p0), 32'd0);
    check("t3_col_wrap", 32'(col_out), 32'h0000_000E);

    // Two rows low on column 0
    p0 = pulses;
    keys = 16'h1001;
    do_ticks(1);
    keys = 16'h1010;
    do_ticks(20);
    check("t4_no_pulse", 32'(pulses - p0), 32'd0);
    keys = '0;
    do_ticks(2);

    // Long hold with release bounce
    p0 = pulses;
    keys = 16'h0040;
    do_ticks(100);
    keys = '0;
    do_ticks(2);
    keys = 16'h0040;
    do_ticks(1);
    keys = '0;
    do_ticks(3);
    check("t5_held_after_3", 32'(key_held), 32'd1);
    do_ticks(1);
    check("t5_released", 32'(key_held), 32'd0);
    check("t5_one_pulse", 32'(pulses - p0), 32'd1);

    // Reset in the middle of debounce
    keys = 16'h8000;
    for (int i = 0; i < 12 && !(m_mode == M_QUAL && m_run == 2); i++) do_ticks(1);
    p0 = pulses;
    do_reset(1);
    keys = '0;
    do_ticks(10);
    check("t6_no_pulse", 32'(pulses - p0), 32'd0);

    // Randomized key activity
    for (int it = 0; it < 150; it++) begin
      sel = $urandom_range(0, 9);
      k1 = $urandom_range(0, 15);
      k2 = $urandom_range(0, 15);
      if (sel < 3) keys = '0;
      else if (sel < 9) keys = 16'(1 << k1);
      else keys = 16'((1 << k1) | (1 << k2));
      do_ticks($urandom_range(1, 8));
    end
    keys = '0;
    do_ticks(12);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
